// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: shares one combinational ALU between the main datapath
// (port 0) and the branch/compare unit (port 1). It arbitrates round-robin,
// drives the ALU from registers and returns the result over a valid/ready
// handshake. At most one operation is in flight at a time.
module alu_request_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int SHW   = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ReqValid,
    output logic [1:0]       ReqReady,
    input  logic [WIDTH-1:0] ReqA0,
    input  logic [WIDTH-1:0] ReqB0,
    input  logic [WIDTH-1:0] ReqA1,
    input  logic [WIDTH-1:0] ReqB1,
    input  logic [OPW-1:0]   ReqOps0,
    input  logic [OPW-1:0]   ReqOps1,
    input  logic [SHW-1:0]   ReqShamt0,
    input  logic [SHW-1:0]   ReqShamt1,
    output logic [1:0]       RespValid,
    input  logic [1:0]       RespReady,
    output logic [WIDTH-1:0] RespData,
    output logic             RespCarry,
    output logic             RespZero,
    output logic             RespSign,
    output logic             RespEqual,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [OPW-1:0]   AluOps,
    output logic [SHW-1:0]   AluShamt,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluCarry,
    input  logic             AluZero,
    input  logic             AluSign,
    input  logic             AluEqual,
    output logic             Busy,
    output logic [CNTW-1:0]  GrantCnt0,
    output logic [CNTW-1:0]  GrantCnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic       prio;       // port favoured when both request
    logic       gntId;      // port owning the in-flight operation
    logic [1:0] grant;      // one-hot grant, only non-zero in IDLE
    logic       gntSel;
    logic       respDone;

    // Saturating increment for the per-port grant counters.
    function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next state and round-robin grant selection.
    always_comb begin
        stateNext = state;
        grant     = 2'b00;
        respDone  = 1'b0;
        case (state)
            IDLE: begin
                unique case (ReqValid)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = prio ? 2'b10 : 2'b01;
                    default: grant = 2'b00;
                endcase
                if (grant != 2'b00) begin
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                stateNext = RESP;
            end
            RESP: begin
                respDone = RespReady[gntId];
                if (respDone) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign gntSel   = grant[1];
    assign ReqReady = grant & {2{rst}};
    assign Busy     = (state != IDLE);

    // State, operand stage, result capture and grant counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            gntId     <= 1'b0;
            AluA      <= '0;
            AluB      <= '0;
            AluOps    <= '0;
            AluShamt  <= '0;
            RespValid <= 2'b00;
            RespData  <= '0;
            RespCarry <= 1'b0;
            RespZero  <= 1'b0;
            RespSign  <= 1'b0;
            RespEqual <= 1'b0;
            GrantCnt0 <= '0;
            GrantCnt1 <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        gntId    <= gntSel;
                        AluA     <= gntSel ? ReqA1 : ReqA0;
                        AluB     <= gntSel ? ReqB1 : ReqB0;
                        AluOps   <= gntSel ? ReqOps1 : ReqOps0;
                        AluShamt <= gntSel ? ReqShamt1 : ReqShamt0;
                        if (gntSel) begin
                            GrantCnt1 <= satInc(GrantCnt1);
                        end else begin
                            GrantCnt0 <= satInc(GrantCnt0);
                        end
                    end
                end
                EXEC: begin
                    RespData  <= AluOut;
                    RespCarry <= AluCarry;
                    RespZero  <= AluZero;
                    RespSign  <= AluSign;
                    RespEqual <= AluEqual;
                    RespValid <= gntId ? 2'b10 : 2'b01;
                end
                RESP: begin
                    if (respDone) begin
                        RespValid <= 2'b00;
                        prio      <= ~gntId;
                    end
                end
                default: begin
                    RespValid <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Testbench for alu_request_arbiter: behavioural ALU stub plus a
// transaction-level reference model of arbitration, latency and counters.
module tb_alu_request_arbiter;

    localparam int W    = 32;
    localparam int OPW  = 4;
    localparam int SHW  = 5;
    localparam int CNTW = 2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_SHLL = 4'b0100;
    localparam logic [3:0] OP_SHRL = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_COMP = 4'b1111;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      ReqValid, ReqReady, RespValid, RespReady;
    logic [W-1:0]    ReqA0, ReqB0, ReqA1, ReqB1;
    logic [OPW-1:0]  ReqOps0, ReqOps1;
    logic [SHW-1:0]  ReqShamt0, ReqShamt1;
    logic [W-1:0]    RespData;
    logic            RespCarry, RespZero, RespSign, RespEqual;
    logic [W-1:0]    AluA, AluB, AluOut;
    logic [OPW-1:0]  AluOps;
    logic [SHW-1:0]  AluShamt;
    logic            AluCarry, AluZero, AluSign, AluEqual;
    logic            Busy;
    logic [CNTW-1:0] GrantCnt0, GrantCnt1;

    int checks = 0;
    int errors = 0;
    int prioM  = 0;
    int cntM[2];
    logic [W+3:0] obs;

    always #5 clk = ~clk;

    alu_request_arbiter #(.WIDTH(W), .OPW(OPW), .SHW(SHW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
        .ReqOps0(ReqOps0), .ReqOps1(ReqOps1),
        .ReqShamt0(ReqShamt0), .ReqShamt1(ReqShamt1),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespData(RespData), .RespCarry(RespCarry), .RespZero(RespZero),
        .RespSign(RespSign), .RespEqual(RespEqual),
        .AluA(AluA), .AluB(AluB), .AluOps(AluOps), .AluShamt(AluShamt),
        .AluOut(AluOut), .AluCarry(AluCarry), .AluZero(AluZero),
        .AluSign(AluSign), .AluEqual(AluEqual),
        .Busy(Busy), .GrantCnt0(GrantCnt0), .GrantCnt1(GrantCnt1)
    );

    // Behavioural ALU: returns {carry, zero, sign, equal, output}.
    function automatic logic [W+3:0] aluCalc(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op, input logic [4:0] sh);
        logic [W:0]   t;
        logic [W-1:0] o;
        logic         c;
        t = '0;
        o = '0;
        c = 1'b0;
        case (op)
            OP_AND:  o = a & b;
            OP_OR:   o = a | b;
            OP_XOR:  o = a ^ b;
            OP_SHLL: o = a << sh;
            OP_SHRL: o = a >> sh;
            OP_ADD: begin
                t = {1'b0, a} + {1'b0, b};
                o = t[W-1:0];
                c = t[W];
            end
            OP_SUB, OP_COMP: begin
                t = {1'b0, a} - {1'b0, b};
                o = t[W-1:0];
                c = t[W];
            end
            default: o = a;
        endcase
        return {c, (o == '0), o[W-1], (a == b), o};
    endfunction

    always_comb begin
        {AluCarry, AluZero, AluSign, AluEqual, AluOut} = aluCalc(AluA, AluB, AluOps, AluShamt);
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkVal({tag, "_reqReady"}, ReqReady, 0);
        checkVal({tag, "_respValid"}, RespValid, 0);
        checkVal({tag, "_respData"}, RespData, 0);
        checkVal({tag, "_flags"}, {RespCarry, RespZero, RespSign, RespEqual}, 0);
        checkVal({tag, "_aluA"}, AluA, 0);
        checkVal({tag, "_aluB"}, AluB, 0);
        checkVal({tag, "_aluOps"}, AluOps, 0);
        checkVal({tag, "_aluShamt"}, AluShamt, 0);
        checkVal({tag, "_busy"}, Busy, 0);
        checkVal({tag, "_cnt0"}, GrantCnt0, 0);
        checkVal({tag, "_cnt1"}, GrantCnt1, 0);
    endtask

    function automatic logic [3:0] pickOp();
        case ($urandom_range(0, 7))
            0: return OP_AND;
            1: return OP_OR;
            2: return OP_XOR;
            3: return OP_SHLL;
            4: return OP_SHRL;
            5: return OP_ADD;
            6: return OP_SUB;
            default: return OP_COMP;
        endcase
    endfunction

    task automatic doReset();
        rst = 1'b0;
        ReqValid = 2'b00;
        RespReady = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        prioM = 0;
        cntM[0] = 0;
        cntM[1] = 0;
    endtask

    // One full transaction: request, EXEC, RESP with `hold` back-pressure cycles, release.
    task automatic doTxn(input logic [1:0] valid,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] op0, input logic [4:0] sh0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] op1, input logic [4:0] sh1,
                         input int hold, output logic [W+3:0] res);
        int           ep;
        logic [1:0]   oh;
        logic [W+3:0] exp;
        ReqValid = valid;
        ReqA0 = a0; ReqB0 = b0; ReqOps0 = op0; ReqShamt0 = sh0;
        ReqA1 = a1; ReqB1 = b1; ReqOps1 = op1; ReqShamt1 = sh1;
        RespReady = 2'b00;
        #1;
        ep  = (valid == 2'b11) ? prioM : (valid[1] ? 1 : 0);
        oh  = (ep == 1) ? 2'b10 : 2'b01;
        exp = (ep == 1) ? aluCalc(a1, b1, op1, sh1) : aluCalc(a0, b0, op0, sh0);
        checkVal("reqReady_idle", ReqReady, oh);
        @(posedge clk); #1;
        cntM[ep] = (cntM[ep] < 3) ? cntM[ep] + 1 : 3;
        ReqA0 = $urandom; ReqB0 = $urandom; ReqA1 = $urandom; ReqB1 = $urandom;
        ReqValid = 2'b11;
        #1;
        checkVal("exec_busy", Busy, 1);
        checkVal("exec_aluA", AluA, (ep == 1) ? a1 : a0);
        checkVal("exec_aluB", AluB, (ep == 1) ? b1 : b0);
        checkVal("exec_aluOps", AluOps, (ep == 1) ? op1 : op0);
        checkVal("exec_aluShamt", AluShamt, (ep == 1) ? sh1 : sh0);
        checkVal("exec_respValid", RespValid, 0);
        checkVal("exec_reqReady", ReqReady, 0);
        checkVal("cnt0", GrantCnt0, cntM[0]);
        checkVal("cnt1", GrantCnt1, cntM[1]);
        @(posedge clk); #1;
        checkVal("resp_valid", RespValid, oh);
        checkVal("resp_result", {RespCarry, RespZero, RespSign, RespEqual, RespData}, exp);
        checkVal("resp_reqReady", ReqReady, 0);
        res = {RespCarry, RespZero, RespSign, RespEqual, RespData};
        for (int k = 0; k < hold; k++) begin
            RespReady = ~oh;
            @(posedge clk); #1;
            checkVal("hold_valid", RespValid, oh);
            checkVal("hold_result", {RespCarry, RespZero, RespSign, RespEqual, RespData}, exp);
            checkVal("hold_reqReady", ReqReady, 0);
        end
        RespReady = oh;
        @(posedge clk); #1;
        prioM = 1 - ep;
        checkVal("done_respValid", RespValid, 0);
        checkVal("done_busy", Busy, 0);
        checkVal("done_nextGrant", ReqReady, (prioM == 1) ? 2'b10 : 2'b01);
        ReqValid = 2'b00;
        RespReady = 2'b00;
    endtask

    initial begin
        rst = 1'b0;
        ReqValid = 2'b11;
        RespReady = 2'b00;
        ReqA0 = '0; ReqB0 = '0; ReqA1 = '0; ReqB1 = '0;
        ReqOps0 = '0; ReqOps1 = '0; ReqShamt0 = '0; ReqShamt1 = '0;
        cntM[0] = 0;
        cntM[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        checkZeros("reset");
        doReset();

        // Port 0 alone: add.
        doTxn(2'b01, 234, 523, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, obs);
        checkVal("add_757", obs[W-1:0], 757);
        checkVal("add_cnt0", GrantCnt0, 1);

        // Both ports after reset: port 0 AND first, then port 1 shll with back-pressure.
        doReset();
        doTxn(2'b11, 234, 523, OP_AND, 0, 234, 0, OP_SHLL, 2, 0, obs);
        checkVal("and_10", obs[W-1:0], 10);
        doTxn(2'b11, 234, 523, OP_AND, 0, 234, 0, OP_SHLL, 2, 5, obs);
        checkVal("shll_936", obs[W-1:0], 936);

        // Compare flags.
        doTxn(2'b01, 234, 234, OP_COMP, 0, 0, 0, OP_ADD, 0, 1, obs);
        checkVal("comp_eq", obs[W], 1);
        checkVal("comp_eq_zero", obs[W+2], 1);
        doTxn(2'b01, 234, 1, OP_COMP, 0, 0, 0, OP_ADD, 0, 0, obs);
        checkVal("comp_ne", obs[W], 0);
        checkVal("comp_ne_zero", obs[W+2], 0);
        checkVal("comp_ne_sign", obs[W+1], 0);

        // Reset while in EXEC: request dropped with no response.
        ReqValid = 2'b10;
        ReqA1 = 77; ReqB1 = 5; ReqOps1 = OP_ADD; ReqShamt1 = 0;
        @(posedge clk); #1;
        checkVal("midrst_busy", Busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        checkZeros("midrst");
        rst = 1'b1;
        ReqValid = 2'b00;
        prioM = 0;
        cntM[0] = 0;
        cntM[1] = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkVal("midrst_noResp", RespValid, 0);
            checkVal("midrst_idle", Busy, 0);
        end

        // Counter saturation at CNTW=2.
        for (int k = 0; k < 5; k++) begin
            doTxn(2'b01, $urandom, $urandom, pickOp(), 5'($urandom_range(0, 31)),
                  0, 0, OP_ADD, 0, 0, obs);
        end
        checkVal("sat_cnt0", GrantCnt0, 3);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            doTxn(2'($urandom_range(1, 3)),
                  $urandom, $urandom, pickOp(), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, pickOp(), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), obs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
